// File: rtl/rs232_pkg.sv
// Shared types and helpers for the RS-232 stream receiver.
// The PARITY state exists only when RS232_RECV_PARITY_EN is defined.
package rs232_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START,
    ST_DATA,
`ifdef RS232_RECV_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  // Clocks per bit, rounded to nearest.
  function automatic int unsigned calc_unit(input int unsigned clock_freq,
                                            input int unsigned baud_rate);
    return (clock_freq + baud_rate / 2) / baud_rate;
  endfunction

endpackage

// File: rtl/rs232_recv_fifo.sv
// First-word-fall-through receive FIFO with almost-full flag and overrun pulse.
// All outputs come straight from flops.
module rs232_recv_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AFULL = 6
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             afull,
  output logic             overrun
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("rs232_recv_fifo: DEPTH must be a power of two and at least 2");
  end
  if (AFULL < 1 || AFULL > DEPTH) begin : g_afull_check
    $error("rs232_recv_fifo: AFULL must be in 1..DEPTH");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d;
  logic             afull_q, afull_d;
  logic             overrun_q, overrun_d;
  logic             full_c, push_ok_c, pop_c;

  // A pop in the same cycle never makes room for a push into a full FIFO.
  always_comb begin
    mem_d      = mem_q;
    full_c     = (count_q == CW'(DEPTH));
    pop_c      = rd_valid_q && rd_ready;
    push_ok_c  = push && !full_c;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push_ok_c) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d    = count_q + CW'(push_ok_c) - CW'(pop_c);
    rd_valid_d = (count_d != '0);
    rd_data_d  = mem_d[rd_ptr_d];
    afull_d    = (count_d >= CW'(AFULL));
    overrun_d  = push && full_c;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      afull_q    <= 1'b1;
      overrun_q  <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      afull_q    <= afull_d;
      overrun_q  <= overrun_d;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign afull    = afull_q;
  assign overrun  = overrun_q;

endmodule

// File: rtl/rs232_recv_stream.sv
// RS-232 receiver: 3-sample majority vote per bit, break detection, FWFT FIFO
// with CTS flow control. Define RS232_RECV_PARITY_EN for 8E1 with parity_err.
module rs232_recv_stream
  import rs232_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 133000000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned AFULL      = 6
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       txd_pin,
  output logic       ctsn_pin,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun,
`ifdef RS232_RECV_PARITY_EN
  output logic       parity_err,
`endif
  output logic       brk
);

  localparam int unsigned UNIT = calc_unit(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned MID  = UNIT / 2;
  localparam int unsigned TW   = $clog2(UNIT);

  if (UNIT < 8) begin : g_unit_check
    $error("rs232_recv_stream: fewer than 8 clocks per bit");
  end

  rx_state_e     state_q, state_d;
  logic          sync1_q, sync2_q;
  logic [1:0]    sync_ok_q, sync_ok_d;
  logic          armed_q, armed_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    samp_q, samp_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          frame_err_q, frame_err_d;
  logic          brk_q, brk_d;
  logic          parity_err_q, parity_err_d;
  logic          at_vote_c, vote_c, push_c;

  assign at_vote_c = (timer_q == TW'(MID + 1));
  assign vote_c    = (samp_q[0] & samp_q[1]) | (samp_q[0] & sync2_q) | (samp_q[1] & sync2_q);

  // Line synchronizer; sync_ok marks when sync2 reflects the real line again.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      sync_ok_q <= '0;
      armed_q   <= 1'b0;
    end else begin
      sync1_q   <= txd_pin;
      sync2_q   <= sync1_q;
      sync_ok_q <= sync_ok_d;
      armed_q   <= armed_d;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      samp_q       <= '1;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      frame_err_q  <= 1'b0;
      brk_q        <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      samp_q       <= samp_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      frame_err_q  <= frame_err_d;
      brk_q        <= brk_d;
      parity_err_q <= parity_err_d;
    end
  end

  // Bit timer free-runs mod UNIT through a frame; states advance at bit centres.
  always_comb begin
    state_d      = state_q;
    timer_d      = (timer_q == TW'(UNIT - 1)) ? '0 : timer_q + TW'(1);
    samp_d       = samp_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    push_c       = 1'b0;
    sync_ok_d    = {sync_ok_q[0], 1'b1};
    // Only a high line seen after reset arms start detection, so a reset
    // released mid-frame never picks up the tail of that frame.
    armed_d      = armed_q | (sync_ok_q[1] & sync2_q);

    if (timer_q == TW'(MID - 1)) samp_d[0] = sync2_q;
    if (timer_q == TW'(MID))     samp_d[1] = sync2_q;

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (armed_q && !sync2_q) state_d = ST_START;
      end
      ST_START: begin
        if (at_vote_c) begin
          bit_cnt_d = '0;
          state_d   = vote_c ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (at_vote_c) begin
          shift_d   = {vote_c, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef RS232_RECV_PARITY_EN
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
`else
          if (bit_cnt_q == 3'd7) state_d = ST_STOP;
`endif
        end
      end
`ifdef RS232_RECV_PARITY_EN
      ST_PARITY: begin
        if (at_vote_c) begin
          parity_err_d = (vote_c != ^shift_q);
          state_d      = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (at_vote_c) begin
          if (vote_c) begin
            push_c  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = (shift_q == 8'h00) ? ST_BREAK : ST_IDLE;
          end
        end
      end
      ST_BREAK: begin
        timer_d = '0;
        if (sync2_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    brk_d = (state_d == ST_BREAK);
  end

  rs232_recv_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH),
    .AFULL (AFULL)
  ) u_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (push_c),
    .push_data (shift_q),
    .rd_ready  (ready),
    .rd_data   (data),
    .rd_valid  (valid),
    .afull     (ctsn_pin),
    .overrun   (overrun)
  );

  assign frame_err = frame_err_q;
  assign brk       = brk_q;
`ifdef RS232_RECV_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_rs232_recv_stream.sv
// Self-checking bench for rs232_recv_stream at 10 clocks per bit.
`timescale 1ns/1ps
module tb_rs232_recv_stream;

  localparam int unsigned CLK_HZ   = 1152000;
  localparam int unsigned BAUD     = 115200;
  localparam int unsigned BIT_CLKS = 10;
  localparam int unsigned DEPTH    = 8;
  localparam int unsigned AFULL    = 6;

  logic       clock = 1'b0;
  logic       resetn;
  logic       txd_pin;
  logic       ctsn_pin;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frame_err;
  logic       overrun;
  logic       brk;
  logic       parity_err;

  int checks = 0;
  int passes = 0;

  rs232_recv_stream #(
    .CLOCK_FREQ (CLK_HZ),
    .BAUD_RATE  (BAUD),
    .DEPTH      (DEPTH),
    .AFULL      (AFULL)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .txd_pin    (txd_pin),
    .ctsn_pin   (ctsn_pin),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
`ifdef RS232_RECV_PARITY_EN
    .parity_err (parity_err),
`endif
    .brk        (brk)
  );

`ifndef RS232_RECV_PARITY_EN
  assign parity_err = 1'b0;
`endif

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Observer: collects delivered bytes and pulse counts away from the edge.
  logic [7:0] rx_q[$];
  int         fe_cnt, ov_cnt, pe_cnt, valid_cycles, stab_err, last_rise;
  logic       hold_q = 1'b0;
  logic       valid_prev = 1'b0;
  logic [7:0] hold_data = 8'h00;

  always @(negedge clock) begin
    if (resetn !== 1'b1) begin
      hold_q     = 1'b0;
      valid_prev = 1'b0;
    end else begin
      if (hold_q && (valid !== 1'b1 || data !== hold_data)) stab_err++;
      if (valid === 1'b1 && ready === 1'b1) rx_q.push_back(data);
      if (valid === 1'b1) valid_cycles++;
      if (valid === 1'b1 && !valid_prev) last_rise = cyc;
      if (frame_err === 1'b1) fe_cnt++;
      if (overrun === 1'b1) ov_cnt++;
      if (parity_err === 1'b1) pe_cnt++;
      valid_prev = (valid === 1'b1);
      hold_q     = (valid === 1'b1 && ready === 1'b0);
      hold_data  = data;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_mon();
    rx_q.delete();
    fe_cnt = 0; ov_cnt = 0; pe_cnt = 0;
    valid_cycles = 0; stab_err = 0; last_rise = -1;
  endtask

  task automatic drive_bit(input logic b);
    txd_pin = b;
    repeat (BIT_CLKS) tick();
  endtask

  task automatic send_raw(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) drive_bit(bits[i]);
    txd_pin = 1'b1;
  endtask

  // Frame = start 0, data LSB first, [even parity], stop.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [10:0] fr;
    fr      = '1;
    fr[0]   = 1'b0;
    fr[8:1] = b;
`ifdef RS232_RECV_PARITY_EN
    fr[9]  = ^b;
    fr[10] = stop;
    send_raw(fr, 11);
`else
    fr[9] = stop;
    send_raw(fr, 10);
`endif
  endtask

  task automatic test_reset();
    resetn = 1'b0; txd_pin = 1'b1; ready = 1'b0;
    repeat (3) tick();
    checks++; if (valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", valid); else passes++;
    checks++; if (data !== 8'h00) $display("FAIL reset_data got=%h exp=00", data); else passes++;
    checks++; if (ctsn_pin !== 1'b1) $display("FAIL reset_ctsn got=%b exp=1", ctsn_pin); else passes++;
    checks++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err got=%b exp=0", frame_err); else passes++;
    checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun got=%b exp=0", overrun); else passes++;
    checks++; if (brk !== 1'b0) $display("FAIL reset_brk got=%b exp=0", brk); else passes++;
    resetn = 1'b1;
    repeat (10) tick();
    checks++; if (ctsn_pin !== 1'b0) $display("FAIL idle_ctsn got=%b exp=0", ctsn_pin); else passes++;
  endtask

  task automatic test_single();
    int t0;
    ready = 1'b1;
    clear_mon();
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    repeat (20) tick();
    checks++; if (rx_q.size() !== 1) $display("FAIL single_count got=%0d exp=1", rx_q.size()); else passes++;
    if (rx_q.size() > 0) begin
      checks++; if (rx_q[0] !== 8'hA5) $display("FAIL single_data got=%h exp=a5", rx_q[0]); else passes++;
    end
    checks++; if (valid_cycles !== 1) $display("FAIL single_valid_width got=%0d exp=1", valid_cycles); else passes++;
    checks++;
    if (last_rise - t0 < 94 || last_rise - t0 > 104)
      $display("FAIL single_latency got=%0d exp=94..104", last_rise - t0);
    else passes++;
    checks++; if (fe_cnt !== 0) $display("FAIL single_frame_err got=%0d exp=0", fe_cnt); else passes++;
  endtask

  task automatic test_glitch();
    ready = 1'b1;
    clear_mon();
    txd_pin = 1'b0;
    repeat (3) tick();
    txd_pin = 1'b1;
    repeat (30) tick();
    checks++; if (valid_cycles !== 0) $display("FAIL glitch_valid got=%0d exp=0", valid_cycles); else passes++;
    checks++; if (fe_cnt !== 0) $display("FAIL glitch_frame_err got=%0d exp=0", fe_cnt); else passes++;
    send_frame(8'h3C, 1'b1);
    repeat (20) tick();
    checks++;
    if (rx_q.size() !== 1 || rx_q[0] !== 8'h3C)
      $display("FAIL glitch_followup got_n=%0d got=%h exp=3c", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    else passes++;
  endtask

  task automatic test_frame_err();
    ready = 1'b1;
    clear_mon();
    send_frame(8'h3C, 1'b0);
    repeat (30) tick();
    checks++; if (fe_cnt !== 1) $display("FAIL ferr_pulses got=%0d exp=1", fe_cnt); else passes++;
    checks++; if (valid_cycles !== 0) $display("FAIL ferr_valid got=%0d exp=0", valid_cycles); else passes++;
    checks++; if (brk !== 1'b0) $display("FAIL ferr_brk got=%b exp=0", brk); else passes++;
  endtask

  task automatic test_flow_control();
    int level;
    ready = 1'b0;
    clear_mon();
    for (int k = 1; k <= 9; k++) begin
      send_frame(8'(k), 1'b1);
      repeat (5) tick();
      level = (k < int'(DEPTH)) ? k : int'(DEPTH);
      checks++;
      if (ctsn_pin !== logic'(level >= int'(AFULL)))
        $display("FAIL flow_ctsn byte=%0d got=%b exp=%b", k, ctsn_pin, level >= int'(AFULL));
      else passes++;
      checks++;
      if (ov_cnt !== ((k > int'(DEPTH)) ? 1 : 0))
        $display("FAIL flow_overrun byte=%0d got=%0d exp=%0d", k, ov_cnt, (k > int'(DEPTH)) ? 1 : 0);
      else passes++;
    end
    ready = 1'b1;
    repeat (20) tick();
    checks++; if (rx_q.size() !== int'(DEPTH)) $display("FAIL flow_drain_count got=%0d exp=%0d", rx_q.size(), DEPTH); else passes++;
    for (int i = 0; i < rx_q.size() && i < int'(DEPTH); i++) begin
      checks++;
      if (rx_q[i] !== 8'(i + 1)) $display("FAIL flow_drain_data idx=%0d got=%h exp=%h", i, rx_q[i], 8'(i + 1));
      else passes++;
    end
    checks++; if (stab_err !== 0) $display("FAIL flow_hold_stable got=%0d exp=0", stab_err); else passes++;
    checks++; if (valid !== 1'b0 || ctsn_pin !== 1'b0) $display("FAIL flow_empty got=%b%b exp=00", valid, ctsn_pin); else passes++;
  endtask

  task automatic test_break();
    ready = 1'b1;
    clear_mon();
    txd_pin = 1'b0;
    repeat (20 * BIT_CLKS) tick();
    checks++; if (brk !== 1'b1) $display("FAIL break_level got=%b exp=1", brk); else passes++;
    checks++; if (fe_cnt !== 1) $display("FAIL break_frame_err got=%0d exp=1", fe_cnt); else passes++;
    txd_pin = 1'b1;
    repeat (2) tick();
    checks++; if (brk !== 1'b1) $display("FAIL break_hold_sync got=%b exp=1", brk); else passes++;
    tick();
    checks++; if (brk !== 1'b0) $display("FAIL break_release got=%b exp=0", brk); else passes++;
    repeat (30) tick();
    checks++;
    if (fe_cnt !== 1 || valid_cycles !== 0) $display("FAIL break_after got_fe=%0d got_valid=%0d exp=1,0", fe_cnt, valid_cycles);
    else passes++;
  endtask

  task automatic test_reset_mid_frame();
    ready = 1'b1;
    clear_mon();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    txd_pin = 1'b0;
    repeat (3) tick();
    resetn = 1'b0;
    repeat (2) tick();
    checks++;
    if ({valid, data, ctsn_pin, brk, frame_err, overrun} !== {1'b0, 8'h00, 1'b1, 3'b000})
      $display("FAIL midreset_outputs got=%b %h %b %b %b %b exp=0 00 1 0 0 0", valid, data, ctsn_pin, brk, frame_err, overrun);
    else passes++;
    resetn = 1'b1;
    repeat (5) tick();
    for (int i = 0; i < 3; i++) drive_bit(1'b0);
    drive_bit(1'b1);
    repeat (20) tick();
    send_frame(8'h5A, 1'b1);
    repeat (20) tick();
    checks++;
    if (rx_q.size() !== 1 || rx_q[0] !== 8'h5A)
      $display("FAIL midreset_next got_n=%0d got=%h exp=5a", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    else passes++;
    checks++; if (fe_cnt !== 0) $display("FAIL midreset_frame_err got=%0d exp=0", fe_cnt); else passes++;
  endtask

  task automatic test_random_stream();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    bit done;
    clear_mon();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          b = 8'($urandom_range(0, 255));
          exp_q.push_back(b);
          send_frame(b, 1'b1);
          repeat ($urandom_range(0, 15)) tick();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    ready = 1'b1;
    repeat (30) tick();
    checks++; if (rx_q.size() !== exp_q.size()) $display("FAIL random_count got=%0d exp=%0d", rx_q.size(), exp_q.size()); else passes++;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) $display("FAIL random_data idx=%0d got=%h exp=%h", i, rx_q[i], exp_q[i]);
      else passes++;
    end
    checks++; if (stab_err !== 0) $display("FAIL random_hold_stable got=%0d exp=0", stab_err); else passes++;
    checks++; if (ov_cnt !== 0 || fe_cnt !== 0 || pe_cnt !== 0) $display("FAIL random_pulses got=%0d/%0d/%0d exp=0/0/0", ov_cnt, fe_cnt, pe_cnt); else passes++;
  endtask

`ifdef RS232_RECV_PARITY_EN
  task automatic test_parity();
    ready = 1'b1;
    clear_mon();
    send_raw({1'b1, 1'b0, 8'h01, 1'b0}, 11);
    repeat (20) tick();
    checks++; if (pe_cnt !== 1) $display("FAIL parity_err_pulses got=%0d exp=1", pe_cnt); else passes++;
    checks++;
    if (rx_q.size() !== 1 || rx_q[0] !== 8'h01)
      $display("FAIL parity_data got_n=%0d got=%h exp=01", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx);
    else passes++;
  endtask
`endif

  initial begin
    clear_mon();
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_flow_control();
    test_break();
    test_reset_mid_frame();
    test_random_stream();
`ifdef RS232_RECV_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
